// File: rtl/uart_tx_if.sv
// Bundles the transmitter's FIFO read port and serial-side outputs.
// master = transmitter side, slave = FIFO / pin side.
interface uart_tx_if #(
    parameter int DataBitsSize = 8
);
    logic                    tx_enable;
    logic                    fifo_empty;
    logic [DataBitsSize-1:0] fifo_q;
    logic                    fifo_read_ack;
    logic                    tx;
    logic                    busy;
    logic                    tx_done;

    modport master (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_q,
        output fifo_read_ack,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output tx_enable,
        output fifo_empty,
        output fifo_q,
        input  fifo_read_ack,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and sends them as
// start bit + DataBitsSize data bits (LSB first) + stop bit.
// Baud timing is a plain clocks-per-bit counter.
module uart_tx #(
    parameter int DataBitsSize = 8,
    parameter int ClksPerBit   = 434
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    uart_tx_if.master bus
);
    localparam int BaudW = $clog2(ClksPerBit);
    localparam int BitW  = $clog2(DataBitsSize) + 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DataBitsSize - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                  r_state;
    logic [BaudW-1:0]        r_baud;
    logic [BitW-1:0]         r_bit;
    logic [DataBitsSize-1:0] r_shift;
    logic                    r_tx;
    logic                    r_busy;

    logic                    w_baud_end;
    logic                    w_can_start;
    logic [DataBitsSize-1:0] w_shift_nxt;

    assign w_baud_end  = (r_baud == BaudLast);
    assign w_can_start = bus.tx_enable & ~bus.fifo_empty;
    assign w_shift_nxt = r_shift >> 1;

    // Frame sequencer; tx and busy are registered so the pin never glitches.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_can_start) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                // Gives the registered FIFO read data a cycle to catch up
                // with the empty flag before it is sampled.
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_shift <= bus.fifo_q;
                    r_baud  <= '0;
                    r_tx    <= 1'b0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= w_shift_nxt;
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == BitLast) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx <= w_shift_nxt[0];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_can_start) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pop pulse and done pulse are pure decodes of the current state/count.
    assign bus.fifo_read_ack = (r_state == S_LOAD);
    assign bus.tx_done       = (r_state == S_STOP) && w_baud_end;
    assign bus.tx            = r_tx;
    assign bus.busy          = r_busy;
endmodule
